// File: rtl/mem_arbiter_nch.sv
// -----------------------------------------------------------------------------
// mem_arbiter_nch
//
// Round-robin arbiter that connects NUM_CH word-oriented requesters to a
// byte-serial 8-bit RAM/IO bus. It handles one transaction at a time. A
// transaction is a byte, half or word load or store. Loads are sign- or
// zero-extended before they are returned. Stores to IO space wait while the
// UART buffer is full. Loads from flushable channels are abandoned on clr.
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   i_rdy            global enable; low freezes every register
//   i_clr            pipeline flush (aborts flushable loads, blocks grants)
//   i_mem_din        RAM/IO read byte, valid the cycle after its address
//   o_mem_dout       write byte
//   o_mem_a          byte address
//   o_mem_wr         1 = write cycle
//   i_io_buffer_full UART buffer full (stalls IO stores)
//   i_req_valid      per-channel request, held until its done pulse
//   i_req_wr         per-channel 1 = store
//   i_req_addr       per-channel byte address, channel c at [32c+31:32c]
//   i_req_size       per-channel size: 0 byte, 1 half, 2/3 word
//   i_req_unsigned   per-channel zero-extend loads when 1
//   i_req_wdata      per-channel store data (low bytes used)
//   o_resp_done      one-hot, one-cycle completion pulse
//   o_resp_rdata     extended load data while a done bit is high
// -----------------------------------------------------------------------------
module mem_arbiter_nch #(
   parameter int                NUM_CH     = 2,
   parameter logic [31:0]       IO_BASE    = 32'h0003_0000,
   parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rdy,
   input  logic                  i_clr,
   input  logic [7:0]            i_mem_din,
   output logic [7:0]            o_mem_dout,
   output logic [31:0]           o_mem_a,
   output logic                  o_mem_wr,
   input  logic                  i_io_buffer_full,
   input  logic [NUM_CH-1:0]     i_req_valid,
   input  logic [NUM_CH-1:0]     i_req_wr,
   input  logic [32*NUM_CH-1:0]  i_req_addr,
   input  logic [2*NUM_CH-1:0]   i_req_size,
   input  logic [NUM_CH-1:0]     i_req_unsigned,
   input  logic [32*NUM_CH-1:0]  i_req_wdata,
   output logic [NUM_CH-1:0]     o_resp_done,
   output logic [31:0]           o_resp_rdata
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_CH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_TAIL, S_DONE} state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [PW-1:0]  r_ptr;
   logic [PW-1:0]  r_ch;
   logic [31:0]    r_addr;
   logic [31:0]    r_data;
   logic           r_wr;
   logic [1:0]     r_size;
   logic           r_unsigned;
   logic           r_is_io;
   logic [1:0]     r_k;
   logic [1:0]     r_last_k;

   // Per-channel views of the flattened request buses
   logic [31:0]    w_ch_addr  [NUM_CH];
   logic [31:0]    w_ch_wdata [NUM_CH];
   logic [1:0]     w_ch_size  [NUM_CH];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign w_ch_addr[gi]  = i_req_addr[32*gi +: 32];
         assign w_ch_wdata[gi] = i_req_wdata[32*gi +: 32];
         assign w_ch_size[gi]  = i_req_size[2*gi +: 2];
      end
   endgenerate

   // Round-robin search: scan cyclically starting just after r_ptr
   logic           w_found;
   logic [PW-1:0]  w_gnt_idx;
   logic [PW-1:0]  w_cand;

   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = r_ptr;
      w_cand    = r_ptr;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cand = (w_cand == PTR_LAST) ? '0 : w_cand + 1'b1;
         if (!w_found && i_req_valid[w_cand]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   logic [31:0]    w_sel_addr;
   logic [31:0]    w_sel_wdata;
   logic [1:0]     w_sel_size;
   logic [1:0]     w_sel_last_k;
   logic           w_grant;
   logic           w_flush;
   logic           w_stall;

   assign w_sel_addr  = w_ch_addr[w_gnt_idx];
   assign w_sel_wdata = w_ch_wdata[w_gnt_idx];
   assign w_sel_size  = w_ch_size[w_gnt_idx];

   always_comb begin
      case (w_sel_size)
         2'd0:    w_sel_last_k = 2'd0;
         2'd1:    w_sel_last_k = 2'd1;
         default: w_sel_last_k = 2'd3;
      endcase
   end

   assign w_grant = (r_state == S_IDLE) && !i_clr && w_found;
   // Only meaningful in ISSUE/TAIL; stores never abort
   assign w_flush = i_clr && !r_wr && FLUSH_MASK[r_ch];
   // The IO store byte is held back while the UART cannot take it
   assign w_stall = (r_state == S_ISSUE) && r_wr && r_is_io && i_io_buffer_full;

   // Read capture: the byte addressed last cycle arrives now
   logic           w_cap_en;
   logic [1:0]     w_cap_idx;

   assign w_cap_en  = !r_wr && (((r_state == S_ISSUE) && (r_k != 2'd0)) ||
                                (r_state == S_TAIL));
   assign w_cap_idx = (r_state == S_TAIL) ? r_last_k : (r_k - 2'd1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else if (i_rdy) begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (w_flush)
               w_state_next = S_IDLE;
            else if (!w_stall && (r_k == r_last_k))
               w_state_next = r_wr ? S_DONE : S_TAIL;
         end
         S_TAIL:  w_state_next = w_flush ? S_IDLE : S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= PTR_LAST;
         r_ch       <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_wr       <= 1'b0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_is_io    <= 1'b0;
         r_k        <= '0;
         r_last_k   <= '0;
      end else if (i_rdy) begin
         if (w_grant) begin
            r_ptr      <= w_gnt_idx;
            r_ch       <= w_gnt_idx;
            r_addr     <= w_sel_addr;
            r_wr       <= i_req_wr[w_gnt_idx];
            r_size     <= w_sel_size;
            r_unsigned <= i_req_unsigned[w_gnt_idx];
            r_is_io    <= (w_sel_addr >= IO_BASE);
            r_last_k   <= w_sel_last_k;
            r_k        <= '0;
            // Loads assemble into a cleared register so short loads have
            // zero upper bytes before extension
            r_data     <= i_req_wr[w_gnt_idx] ? w_sel_wdata : '0;
         end
         if ((r_state == S_ISSUE) && !w_stall) begin
            r_k <= r_k + 2'd1;
         end
         if (w_cap_en) begin
            case (w_cap_idx)
               2'd0:    r_data[7:0]   <= i_mem_din;
               2'd1:    r_data[15:8]  <= i_mem_din;
               2'd2:    r_data[23:16] <= i_mem_din;
               default: r_data[31:24] <= i_mem_din;
            endcase
         end
      end
   end

   // ---------------- FSM: outputs ----------------
   logic [7:0]     w_wbyte;
   logic [31:0]    w_ext;

   always_comb begin
      case (r_k)
         2'd0:    w_wbyte = r_data[7:0];
         2'd1:    w_wbyte = r_data[15:8];
         2'd2:    w_wbyte = r_data[23:16];
         default: w_wbyte = r_data[31:24];
      endcase
   end

   always_comb begin
      case (r_size)
         2'd0:    w_ext = r_unsigned ? {24'd0, r_data[7:0]}
                                     : {{24{r_data[7]}}, r_data[7:0]};
         2'd1:    w_ext = r_unsigned ? {16'd0, r_data[15:0]}
                                     : {{16{r_data[15]}}, r_data[15:0]};
         default: w_ext = r_data;
      endcase
   end

   always_comb begin
      o_mem_a      = '0;
      o_mem_dout   = '0;
      o_mem_wr     = 1'b0;
      o_resp_done  = '0;
      o_resp_rdata = '0;
      case (r_state)
         S_ISSUE: begin
            o_mem_a = r_addr + {30'd0, r_k};
            if (r_wr) begin
               o_mem_dout = w_wbyte;
               o_mem_wr   = i_rdy && !w_stall;
            end
         end
         S_DONE: begin
            // Gated by rdy so a frozen DONE cannot stretch the pulse
            if (i_rdy) begin
               o_resp_done[r_ch] = 1'b1;
               o_resp_rdata      = r_wr ? 32'd0 : w_ext;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
module tb_mem_arbiter_nch;

   localparam int NCH  = 2;
   localparam int MAXC = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              rdy;
   logic              clr;
   logic [7:0]        mem_din = 8'h00;
   logic [7:0]        mem_dout;
   logic [31:0]       mem_a;
   logic              mem_wr;
   logic              io_full;
   logic [NCH-1:0]    req_valid;
   logic [NCH-1:0]    req_wr;
   logic [32*NCH-1:0] req_addr;
   logic [2*NCH-1:0]  req_size;
   logic [NCH-1:0]    req_uns;
   logic [32*NCH-1:0] req_wdata;
   logic [NCH-1:0]    resp_done;
   logic [31:0]       resp_rdata;

   int checks   = 0;
   int failures = 0;

   mem_arbiter_nch #(.NUM_CH(NCH)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_rdy            (rdy),
      .i_clr            (clr),
      .i_mem_din        (mem_din),
      .o_mem_dout       (mem_dout),
      .o_mem_a          (mem_a),
      .o_mem_wr         (mem_wr),
      .i_io_buffer_full (io_full),
      .i_req_valid      (req_valid),
      .i_req_wr         (req_wr),
      .i_req_addr       (req_addr),
      .i_req_size       (req_size),
      .i_req_unsigned   (req_uns),
      .i_req_wdata      (req_wdata),
      .o_resp_done      (resp_done),
      .o_resp_rdata     (resp_rdata)
   );

   // RAM/IO responder: data for an address appears the following cycle
   logic [7:0] ram [logic [31:0]];
   always @(posedge clk) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

   // Per-cycle record of one transaction, index i = cycle g+i
   logic [31:0]    log_a    [0:MAXC];
   logic           log_wr   [0:MAXC];
   logic [7:0]     log_dout [0:MAXC];
   logic [NCH-1:0] log_done [0:MAXC];
   bit             stim_clr [0:MAXC];
   bit             stim_frz [0:MAXC];
   bit             stim_full[0:MAXC];
   bit             stim_rst [0:MAXC];
   int             drop_at;
   int             done_at;
   int             nwr;
   logic [31:0]    done_rdata;
   logic [NCH-1:0] done_vec;

   task automatic clear_stim();
      for (int i = 0; i <= MAXC; i++) begin
         stim_clr[i] = 0; stim_frz[i] = 0; stim_full[i] = 0; stim_rst[i] = 0;
      end
      drop_at = -1;
   endtask

   // Drives one request from an IDLE negedge (cycle g) and logs MAXC cycles
   task automatic run_txn(input int ch, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata);
      @(negedge clk);
      req_wr[ch]               = wr;
      req_addr[32*ch +: 32]    = addr;
      req_size[2*ch +: 2]      = size;
      req_uns[ch]              = uns;
      req_wdata[32*ch +: 32]   = wdata;
      req_valid[ch]            = 1'b1;
      clr                      = stim_clr[0];
      done_at = -1; done_rdata = '0; done_vec = '0; nwr = 0;
      for (int i = 1; i <= MAXC; i++) begin
         @(negedge clk);
         clr = stim_clr[i]; rdy = !stim_frz[i]; io_full = stim_full[i]; rst = stim_rst[i];
         if (i == drop_at) req_valid[ch] = 1'b0;
         #1;
         log_a[i] = mem_a; log_wr[i] = mem_wr; log_dout[i] = mem_dout; log_done[i] = resp_done;
         if (mem_wr) nwr++;
         if (resp_done != '0 && done_at < 0) begin
            done_at = i; done_rdata = resp_rdata; done_vec = resp_done;
            req_valid[ch] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
      req_valid = '0; req_wr = '0; req_addr = '0; req_size = '0; req_uns = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
         failures++;
         $display("FAIL reset_bus: got a=%h dout=%h wr=%b expected all 0", mem_a, mem_dout, mem_wr);
      end
      checks++;
      if (resp_done !== '0 || resp_rdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_resp: got done=%b rdata=%h expected 0", resp_done, resp_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("txn reset done");
   endtask

   task automatic test_word_load();
      clear_stim();
      run_txn(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (log_a[i] !== 32'h100 + 32'(i - 1) || log_wr[i] !== 1'b0) begin
            failures++;
            $display("FAIL word_load_addr[%0d]: got a=%h wr=%b expected a=%h wr=0",
                     i, log_a[i], log_wr[i], 32'h100 + 32'(i - 1));
         end
      end
      checks++;
      if (done_at !== 6 || done_vec !== 2'b01) begin
         failures++;
         $display("FAIL word_load_done: got cycle=%0d vec=%b expected cycle=6 vec=01", done_at, done_vec);
      end
      checks++;
      if (done_rdata !== 32'h4433_2211) begin
         failures++;
         $display("FAIL word_load_data: got %h expected 44332211", done_rdata);
      end
      checks++;
      if (log_done[7] !== '0 || nwr !== 0) begin
         failures++;
         $display("FAIL word_load_pulse: got done[7]=%b writes=%0d expected 0/0", log_done[7], nwr);
      end
      $display("txn word_load ch0 done_at=%0d rdata=%h", done_at, done_rdata);
   endtask

   task automatic test_extension();
      clear_stim();
      run_txn(1, 1'b0, 32'h200, 2'd0, 1'b0, 32'h0);
      checks++;
      if (done_at !== 3 || done_vec !== 2'b10 || done_rdata !== 32'hFFFF_FF80) begin
         failures++;
         $display("FAIL ext_byte_signed: got cycle=%0d vec=%b data=%h expected 3/10/ffffff80",
                  done_at, done_vec, done_rdata);
      end
      $display("txn byte_signed ch1 rdata=%h", done_rdata);
      run_txn(1, 1'b0, 32'h200, 2'd0, 1'b1, 32'h0);
      checks++;
      if (done_rdata !== 32'h0000_0080) begin
         failures++;
         $display("FAIL ext_byte_unsigned: got %h expected 00000080", done_rdata);
      end
      $display("txn byte_unsigned ch1 rdata=%h", done_rdata);
      run_txn(1, 1'b0, 32'h210, 2'd1, 1'b0, 32'h0);
      checks++;
      if (done_at !== 4 || done_rdata !== 32'hFFFF_8001) begin
         failures++;
         $display("FAIL ext_half_signed: got cycle=%0d data=%h expected 4/ffff8001", done_at, done_rdata);
      end
      $display("txn half_signed ch1 rdata=%h", done_rdata);
   endtask

   task automatic test_round_robin();
      int          n = 0;
      int          seq [4];
      logic [31:0] rd  [4];
      bit          onehot_ok = 1;
      bit          prev = 0;
      @(negedge clk);
      req_wr = '0; req_uns = 2'b11; req_size = 4'b0000;
      req_addr = {32'h301, 32'h300};
      req_valid = 2'b11;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk);
         #1;
         if (resp_done != '0) begin
            if (!$onehot(resp_done) || prev) onehot_ok = 0;
            seq[n] = resp_done[1] ? 1 : 0;
            rd[n]  = resp_rdata;
            n++;
            if (n == 4) req_valid = '0;
            prev = 1;
         end else begin
            prev = 0;
         end
      end
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL rr_count: got %0d dones expected 4 within 40 cycles", n);
      end
      for (int k = 0; k < n; k++) begin
         checks++;
         if (seq[k] !== (k % 2) || rd[k] !== ((k % 2) ? 32'hA5 : 32'h5A)) begin
            failures++;
            $display("FAIL rr_grant[%0d]: got ch=%0d data=%h expected ch=%0d data=%h",
                     k, seq[k], rd[k], k % 2, (k % 2) ? 32'hA5 : 32'h5A);
         end
         $display("txn rr %0d ch=%0d rdata=%h", k, seq[k], rd[k]);
      end
      checks++;
      if (!onehot_ok) begin
         failures++;
         $display("FAIL rr_onehot: got non-one-hot or multi-cycle done expected single one-hot pulses");
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_io_stall();
      clear_stim();
      stim_full[1] = 1; stim_full[2] = 1; stim_full[3] = 1;
      run_txn(0, 1'b1, 32'h0003_0000, 2'd0, 1'b0, 32'h41);
      checks++;
      if (log_wr[1] !== 1'b0 || log_wr[2] !== 1'b0 || log_wr[3] !== 1'b0) begin
         failures++;
         $display("FAIL io_stall_hold: got wr=%b%b%b expected 000", log_wr[1], log_wr[2], log_wr[3]);
      end
      checks++;
      if (log_wr[4] !== 1'b1 || log_a[4] !== 32'h0003_0000 || log_dout[4] !== 8'h41 || nwr !== 1) begin
         failures++;
         $display("FAIL io_stall_write: got wr=%b a=%h dout=%h writes=%0d expected 1/00030000/41/1",
                  log_wr[4], log_a[4], log_dout[4], nwr);
      end
      checks++;
      if (done_at !== 5 || done_rdata !== 32'd0) begin
         failures++;
         $display("FAIL io_stall_done: got cycle=%0d data=%h expected 5/0", done_at, done_rdata);
      end
      $display("txn io_store ch0 done_at=%0d writes=%0d", done_at, nwr);
      // IO reads ignore the buffer-full flag
      clear_stim();
      for (int i = 0; i <= MAXC; i++) stim_full[i] = 1;
      run_txn(0, 1'b0, 32'h0003_0000, 2'd0, 1'b1, 32'h0);
      checks++;
      if (done_at !== 3 || done_rdata !== 32'h7E) begin
         failures++;
         $display("FAIL io_read_nostall: got cycle=%0d data=%h expected 3/0000007e", done_at, done_rdata);
      end
      $display("txn io_load ch0 done_at=%0d rdata=%h", done_at, done_rdata);
   endtask

   task automatic test_clr();
      clear_stim();
      stim_clr[0] = 1;
      run_txn(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      checks++;
      if (log_a[1] !== 32'd0 || log_a[2] !== 32'h100 || done_at !== 7) begin
         failures++;
         $display("FAIL clr_idle: got a1=%h a2=%h done=%0d expected 0/100/7", log_a[1], log_a[2], done_at);
      end
      $display("txn clr_idle ch0 done_at=%0d", done_at);
      clear_stim();
      stim_clr[2] = 1; drop_at = 2;
      run_txn(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      checks++;
      if (done_at !== -1 || log_a[3] !== 32'd0) begin
         failures++;
         $display("FAIL clr_load_abort: got done=%0d a3=%h expected none/0", done_at, log_a[3]);
      end
      $display("txn clr_load ch0 done_at=%0d", done_at);
      clear_stim();
      stim_clr[2] = 1;
      run_txn(0, 1'b1, 32'h400, 2'd2, 1'b0, 32'hDDCC_BBAA);
      checks++;
      if (nwr !== 4 || log_a[1] !== 32'h400 || log_dout[1] !== 8'hAA ||
          log_a[4] !== 32'h403 || log_dout[4] !== 8'hDD) begin
         failures++;
         $display("FAIL clr_store_bytes: got writes=%0d a1=%h d1=%h a4=%h d4=%h expected 4/400/aa/403/dd",
                  nwr, log_a[1], log_dout[1], log_a[4], log_dout[4]);
      end
      checks++;
      if (done_at !== 5 || done_rdata !== 32'd0) begin
         failures++;
         $display("FAIL clr_store_done: got cycle=%0d data=%h expected 5/0", done_at, done_rdata);
      end
      $display("txn clr_store ch0 done_at=%0d writes=%0d", done_at, nwr);
   endtask

   task automatic test_freeze();
      clear_stim();
      stim_frz[2] = 1; stim_frz[3] = 1;
      run_txn(1, 1'b1, 32'h500, 2'd2, 1'b0, 32'h4433_2211);
      checks++;
      if (log_wr[2] !== 1'b0 || log_wr[3] !== 1'b0 || log_a[2] !== 32'h501 || log_a[3] !== 32'h501) begin
         failures++;
         $display("FAIL freeze_hold: got wr=%b%b a=%h/%h expected 00 501/501",
                  log_wr[2], log_wr[3], log_a[2], log_a[3]);
      end
      checks++;
      if (log_wr[4] !== 1'b1 || log_a[4] !== 32'h501 || log_dout[4] !== 8'h22 || nwr !== 4) begin
         failures++;
         $display("FAIL freeze_resume: got wr=%b a=%h d=%h writes=%0d expected 1/501/22/4",
                  log_wr[4], log_a[4], log_dout[4], nwr);
      end
      checks++;
      if (done_at !== 7 || done_vec !== 2'b10) begin
         failures++;
         $display("FAIL freeze_done: got cycle=%0d vec=%b expected 7/10", done_at, done_vec);
      end
      $display("txn freeze_store ch1 done_at=%0d writes=%0d", done_at, nwr);
   endtask

   task automatic test_rst_mid();
      int first = -1;
      logic [NCH-1:0] fvec = '0;
      clear_stim();
      stim_rst[3] = 1; drop_at = 3;
      run_txn(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
      checks++;
      if (done_at !== -1) begin
         failures++;
         $display("FAIL rst_mid_nodone: got done at %0d expected none", done_at);
      end
      checks++;
      if (log_a[4] !== 32'd0 || log_wr[4] !== 1'b0 || log_dout[4] !== 8'd0 || log_done[4] !== '0) begin
         failures++;
         $display("FAIL rst_mid_outputs: got a=%h wr=%b d=%h done=%b expected 0",
                  log_a[4], log_wr[4], log_dout[4], log_done[4]);
      end
      $display("txn rst_mid ch0 done_at=%0d", done_at);
      // Pointer restarts at NUM_CH-1, so channel 0 wins a tie after reset
      @(negedge clk);
      req_wr = '0; req_uns = 2'b11; req_size = 4'b0000;
      req_addr = {32'h301, 32'h300};
      req_valid = 2'b11;
      for (int c = 0; c < 10 && first < 0; c++) begin
         @(negedge clk);
         #1;
         if (resp_done != '0) begin
            first = c; fvec = resp_done;
         end
      end
      req_valid = '0;
      checks++;
      if (first < 0 || fvec !== 2'b01) begin
         failures++;
         $display("FAIL rst_ptr: got first done vec=%b (cycle %0d) expected 01", fvec, first);
      end
      $display("txn rst_ptr first_vec=%b", fvec);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
      ram[32'h200] = 8'h80;
      ram[32'h210] = 8'h01; ram[32'h211] = 8'h80;
      ram[32'h300] = 8'h5A; ram[32'h301] = 8'hA5;
      ram[32'h0003_0000] = 8'h7E;
      clear_stim();
      test_reset();
      test_word_load();
      test_extension();
      test_round_robin();
      test_io_stall();
      test_clr();
      test_freeze();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
